// File: rtl/cm_pkg.sv
// Shared definitions for the complex multiplier / derotator.
// Holds the datapath widths, the pipeline latency, the 16-entry cosine table
// and a lookup function returning the {cos, sin} coefficient pair for a
// 4-bit table index.
package cm_pkg;

   localparam int unsigned CM_IN_W   = 8;
   localparam int unsigned CM_COEF_W = 8;
   localparam int unsigned CM_OUT_W  = 17;
   localparam int unsigned CM_LAT    = 3;

   // round(127 * cos(2*pi*k/16)), k = 0..15; -128 never appears, so negation is safe.
   localparam logic signed [CM_COEF_W-1:0] CM_COS_TBL [16] = '{
      8'sd127,  8'sd117,  8'sd90,   8'sd49,
      8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
     -8'sd127, -8'sd117, -8'sd90,  -8'sd49,
      8'sd0,    8'sd49,   8'sd90,   8'sd117
   };

   // Returns {C[k], S[k]}; sin is cos shifted by a quarter turn: S[k] = C[(k-4) mod 16].
   function automatic logic [2*CM_COEF_W-1:0] cm_coef(input logic [3:0] k);
      logic [3:0] ks;
      ks = k - 4'd4;
      return {CM_COS_TBL[k], CM_COS_TBL[ks]};
   endfunction

endpackage

// File: rtl/cm_phase_gen.sv
// Phase accumulator and coefficient lookup for the derotator.
// Ports:
//   clk, rstb       clock, synchronous active-low reset
//   in_en           sample accepted this cycle (advances the phase)
//   ph_clr          synchronous phase clear (current sample uses phase 0)
//   ph_step         unsigned phase increment per accepted sample
//   c_o, d_o        registered coefficient real/imag parts, aligned with stage 1
module cm_phase_gen
   import cm_pkg::*;
#(
   parameter int unsigned PH_W    = 8,
   parameter bit          ROT_DIR = 1'b0
) (
   input  logic                        clk,
   input  logic                        rstb,
   input  logic                        in_en,
   input  logic                        ph_clr,
   input  logic [PH_W-1:0]             ph_step,
   output logic signed [CM_COEF_W-1:0] c_o,
   output logic signed [CM_COEF_W-1:0] d_o
);

   logic [PH_W-1:0]             ph_q, ph_d, ph_use;
   logic [3:0]                  k;
   logic [2*CM_COEF_W-1:0]      cs;
   logic signed [CM_COEF_W-1:0] s;
   logic signed [CM_COEF_W-1:0] c_d, d_d, c_q, d_q;

   always_comb begin
      // A clear overrides the held phase for the sample presented this cycle.
      ph_use = ph_clr ? '0 : ph_q;
      k      = ph_use[PH_W-1 -: 4];
      cs     = cm_coef(k);
      s      = cs[CM_COEF_W-1:0];
      ph_d   = ph_q;
      c_d    = '0;
      d_d    = '0;
      if (in_en) begin
         ph_d = ph_use + ph_step;
         c_d  = cs[2*CM_COEF_W-1:CM_COEF_W];
         d_d  = ROT_DIR ? -s : s;
      end else if (ph_clr) begin
         ph_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         ph_q <= '0;
         c_q  <= '0;
         d_q  <= '0;
      end else begin
         ph_q <= ph_d;
         c_q  <= c_d;
         d_q  <= d_d;
      end
   end

   assign c_o = c_q;
   assign d_o = d_q;

endmodule

// File: rtl/cm_derotator.sv
// Pipelined complex multiplier / derotator: (in_i + j*in_q) * (c + j*d),
// where c + j*d is a unit phasor from a free-running phase accumulator.
// Fixed latency of 3 clocks, one sample per clock, no backpressure.
// Ports:
//   clk, rstb             clock, synchronous active-low reset
//   in_i, in_q            8-bit signed input sample
//   in_en                 input sample valid
//   ph_step               phase increment per accepted sample
//   ph_clr                synchronous phase clear
//   CM_data_i, CM_data_q  17-bit signed product (zero when CM_en is low)
//   CM_en                 output valid
module cm_derotator
   import cm_pkg::*;
#(
   parameter int unsigned PH_W    = 8,
   parameter bit          ROT_DIR = 1'b0
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic signed [CM_IN_W-1:0]  in_i,
   input  logic signed [CM_IN_W-1:0]  in_q,
   input  logic                       in_en,
   input  logic [PH_W-1:0]            ph_step,
   input  logic                       ph_clr,
   output logic signed [CM_OUT_W-1:0] CM_data_i,
   output logic signed [CM_OUT_W-1:0] CM_data_q,
   output logic                       CM_en
);

   localparam int unsigned PROD_W = CM_IN_W + CM_COEF_W;

   logic [CM_LAT-1:0]           vld_q;
   logic signed [CM_IN_W-1:0]   a_q, b_q;
   logic signed [CM_COEF_W-1:0] c, d;
   logic signed [PROD_W-1:0]    a_x, b_x, c_x, d_x;
   logic signed [PROD_W-1:0]    ac_d, bd_d, ad_d, bc_d;
   logic signed [PROD_W-1:0]    ac_q, bd_q, ad_q, bc_q;
   logic signed [CM_OUT_W-1:0]  out_i_d, out_q_d, out_i_q, out_q_q;

   cm_phase_gen #(
      .PH_W    (PH_W),
      .ROT_DIR (ROT_DIR)
   ) u_phase_gen (
      .clk     (clk),
      .rstb    (rstb),
      .in_en   (in_en),
      .ph_clr  (ph_clr),
      .ph_step (ph_step),
      .c_o     (c),
      .d_o     (d)
   );

   always_comb begin
      // Sign-extend before multiplying so the product is formed at full width.
      a_x  = PROD_W'(a_q);
      b_x  = PROD_W'(b_q);
      c_x  = PROD_W'(c);
      d_x  = PROD_W'(d);
      ac_d = '0;
      bd_d = '0;
      ad_d = '0;
      bc_d = '0;
      if (vld_q[0]) begin
         ac_d = a_x * c_x;
         bd_d = b_x * d_x;
         ad_d = a_x * d_x;
         bc_d = b_x * c_x;
      end
      out_i_d = '0;
      out_q_d = '0;
      if (vld_q[1]) begin
         out_i_d = CM_OUT_W'(ac_q) - CM_OUT_W'(bd_q);
         out_q_d = CM_OUT_W'(ad_q) + CM_OUT_W'(bc_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         vld_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ac_q    <= '0;
         bd_q    <= '0;
         ad_q    <= '0;
         bc_q    <= '0;
         out_i_q <= '0;
         out_q_q <= '0;
      end else begin
         vld_q   <= {vld_q[CM_LAT-2:0], in_en};
         a_q     <= in_en ? in_i : '0;
         b_q     <= in_en ? in_q : '0;
         ac_q    <= ac_d;
         bd_q    <= bd_d;
         ad_q    <= ad_d;
         bc_q    <= bc_d;
         out_i_q <= out_i_d;
         out_q_q <= out_q_d;
      end
   end

   assign CM_data_i = out_i_q;
   assign CM_data_q = out_q_q;
   assign CM_en     = vld_q[CM_LAT-1];

endmodule

// File: tb/tb_cm_derotator.sv
// Scoreboard bench for cm_derotator: one instance per rotation direction,
// shared stimulus; expected results queued at issue time, checked every cycle.
module tb_cm_derotator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rstb;
   logic signed [7:0]  in_i, in_q;
   logic               in_en, ph_clr;
   logic [7:0]         ph_step;
   logic signed [16:0] o0_i, o0_q, o1_i, o1_q;
   logic               o0_en, o1_en;

   cm_derotator #(.PH_W(8), .ROT_DIR(1'b0)) dut0 (
      .clk(clk), .rstb(rstb), .in_i(in_i), .in_q(in_q), .in_en(in_en),
      .ph_step(ph_step), .ph_clr(ph_clr),
      .CM_data_i(o0_i), .CM_data_q(o0_q), .CM_en(o0_en)
   );

   cm_derotator #(.PH_W(8), .ROT_DIR(1'b1)) dut1 (
      .clk(clk), .rstb(rstb), .in_i(in_i), .in_q(in_q), .in_en(in_en),
      .ph_step(ph_step), .ph_clr(ph_clr),
      .CM_data_i(o1_i), .CM_data_q(o1_q), .CM_en(o1_en)
   );

   typedef struct {
      int due;
      int ei;
      int eq;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   mon_on = 1'b0;
   logic [7:0] m_ph = 8'h00;
   int   ct [16] = '{127, 117, 90, 49, 0, -49, -90, -117,
                     -127, -117, -90, -49, 0, 49, 90, 117};

   always @(posedge clk) cyc++;

   function automatic int cosv(int k);
      return ct[k & 15];
   endfunction

   task automatic chk(string nm, int d, logic en, logic signed [16:0] gi, logic signed [16:0] gq,
                      bit we, int wi, int wq);
      n_chk++;
      if (en === we && gi === 17'(wi) && gq === 17'(wq)) n_pass++;
      else $display("FAIL %s dut%0d cyc=%0d: got en=%b i=%0d q=%0d, want en=%b i=%0d q=%0d",
                    nm, d, cyc, en, gi, gq, we, wi, wq);
   endtask

   task automatic mon_one(int d, logic en, logic signed [16:0] gi, logic signed [16:0] gq);
      exp_t e;
      bit   due;
      due = 1'b0;
      if (d == 0) begin
         if (q0.size() > 0) due = (q0[0].due == cyc);
      end else begin
         if (q1.size() > 0) due = (q1[0].due == cyc);
      end
      if (due) begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk("result", d, en, gi, gq, 1'b1, e.ei, e.eq);
      end else begin
         chk("idle", d, en, gi, gq, 1'b0, 0, 0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         mon_one(0, o0_en, o0_i, o0_q);
         mon_one(1, o1_en, o1_i, o1_q);
      end
   end

   // Drives one cycle of stimulus; when a sample is issued the expectation is
   // queued either from hand values (hand=1) or from the reference model.
   task automatic drive(bit en, int i, int q, bit clr, int stp, bit hand,
                        int h0i, int h0q, int h1i, int h1q);
      logic [7:0] use_ph;
      int         k, c, s;
      @(posedge clk);
      #1;
      in_en   = en;
      in_i    = 8'(i);
      in_q    = 8'(q);
      ph_clr  = clr;
      ph_step = 8'(stp);
      use_ph  = clr ? 8'h00 : m_ph;
      k       = int'(use_ph[7:4]);
      if (en) begin
         c = cosv(k);
         s = cosv(k + 12);
         if (hand) begin
            q0.push_back('{cyc + 3, h0i, h0q});
            q1.push_back('{cyc + 3, h1i, h1q});
         end else begin
            q0.push_back('{cyc + 3, i * c - q * s, i * s + q * c});
            q1.push_back('{cyc + 3, i * c + q * s, q * c - i * s});
         end
         m_ph = use_ph + 8'(stp);
      end else if (clr) begin
         m_ph = 8'h00;
      end
   endtask

   task automatic idle(bit clr, int stp);
      drive(1'b0, 0, 0, clr, stp, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic smp_m(int i, int q, bit clr, int stp);
      drive(1'b1, i, q, clr, stp, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic smp_h(int i, int q, bit clr, int stp, int h0i, int h0q, int h1i, int h1q);
      drive(1'b1, i, q, clr, stp, 1'b1, h0i, h0q, h1i, h1q);
   endtask

   // One reset edge; samples not yet at the output are dropped from the scoreboard.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rstb   = 1'b0;
      in_en  = 1'b0;
      ph_clr = 1'b0;
      while (q0.size() > 0 && q0[$].due > cyc) void'(q0.pop_back());
      while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
      m_ph = 8'h00;
      @(posedge clk);
      #1;
      rstb = 1'b1;
   endtask

   initial begin
      rstb    = 1'b0;
      in_i    = '0;
      in_q    = '0;
      in_en   = 1'b0;
      ph_clr  = 1'b0;
      ph_step = '0;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rstb = 1'b1;

      // Phase 0 identity
      idle(1'b1, 0);
      smp_h(100, -50, 1'b0, 0, 12700, -6350, 12700, -6350);
      repeat (4) idle(1'b0, 0);

      // Quarter-turn step: k=0 then k=4
      idle(1'b1, 'h40);
      smp_h(10, 20, 1'b0, 'h40, 1270, 2540, 1270, 2540);
      smp_h(10, 20, 1'b0, 'h40, -2540, 1270, 2540, -1270);

      // Extremes at k=2 (90 + j90)
      smp_h(0, 0, 1'b1, 'h20, 0, 0, 0, 0);
      smp_h(-128, 127, 1'b0, 0, -22950, -90, -90, 22950);
      smp_h(-128, -128, 1'b0, 0, 0, -23040, -23040, 0);
      smp_m(127, -128, 1'b0, 0);
      repeat (4) idle(1'b0, 0);

      // Wrap and bubbles, descending phase
      idle(1'b1, 'hF0);
      for (int j = 0; j < 20; j++) begin
         if ((j % 5) == 1 || (j % 5) == 4) idle(1'b0, 'hF0);
         else smp_m(j * 6 - 60, 50 - j * 5, 1'b0, 'hF0);
      end
      repeat (4) idle(1'b0, 'hF0);

      // Clear together with a sample while ph = 0x80
      idle(1'b1, 'h80);
      smp_h(1, 1, 1'b0, 'h80, 127, 127, 127, 127);
      smp_h(10, 20, 1'b1, 'h30, 1270, 2540, 1270, 2540);
      smp_h(10, 20, 1'b0, 'h30, -1850, 2150, 2830, -190);
      repeat (4) idle(1'b0, 0);

      // Mid-stream reset with two samples in flight
      idle(1'b1, 'h50);
      smp_m(30, -40, 1'b0, 'h50);
      smp_m(-70, 25, 1'b0, 'h50);
      smp_m(55, 66, 1'b0, 'h50);
      smp_m(-9, -99, 1'b0, 'h50);
      do_reset();
      smp_h(100, -50, 1'b0, 'h50, 12700, -6350, 12700, -6350);
      smp_h(10, 20, 1'b0, 'h50, -2830, 190, 1850, -2150);
      repeat (6) idle(1'b0, 0);

      n_chk++;
      if (q0.size() == 0) n_pass++;
      else $display("FAIL leftover dut0: got %0d pending, want 0", q0.size());
      n_chk++;
      if (q1.size() == 0) n_pass++;
      else $display("FAIL leftover dut1: got %0d pending, want 0", q1.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
